// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: CPU load/store handshake to a single-port word RAM.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for req; request fields latched on acceptance
// RD    | RAM word address presented for read
// MRG   | RAM data valid; extract load field or merge partial store
// WR    | RAM write strobe asserted
// ACK   | one-cycle completion pulse (err qualifies it)
module dmem_access_ctrl #(
  parameter logic [31:0] ADDR_BASE  = 32'h10010000,
  parameter int          DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  sext,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic                  ack,
  output logic                  err,
  output logic [31:0]           rdata,
  output logic                  busy,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_MRG, S_WR, S_ACK} state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  sext_q, sext_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            lane_q, lane_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [DEPTH_LOG2-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;

  logic [31:0]           off;
  logic                  out_of_range, misalign, bad_req;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_val, merged;

  assign off          = addr - ADDR_BASE;
  assign out_of_range = off >= (32'd4 << DEPTH_LOG2);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign bad_req = out_of_range || (size == 2'b11) || misalign;

  assign ld_byte = mem_rdata[{lane_q, 3'b000} +: 8];
  assign ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_val = mem_rdata;
    case (size_q)
      2'b00:   ld_val = sext_q ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      2'b01:   ld_val = sext_q ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      default: ld_val = mem_rdata;
    endcase
  end

  // Read-modify-write: only the addressed little-endian lane(s) are replaced.
  always_comb begin
    merged = mem_rdata;
    if (size_q == 2'b00)
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sext_d      = sext_q;
    wdata_d     = wdata_q;
    lane_d      = lane_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          sext_d  = sext;
          wdata_d = wdata;
          lane_d  = off[1:0];
          err_d   = bad_req;
          if (bad_req) begin
            state_d = S_ACK;
          end else if (we && (size == 2'b10)) begin
            mem_addr_d  = off[DEPTH_LOG2+1:2];
            mem_wdata_d = wdata;
            state_d     = S_WR;
          end else begin
            mem_addr_d = off[DEPTH_LOG2+1:2];
            state_d    = S_RD;
          end
        end
      end
      S_RD:  state_d = S_MRG;
      S_MRG: begin
        if (we_q) begin
          mem_wdata_d = merged;
          state_d     = S_WR;
        end else begin
          rdata_d = ld_val;
          state_d = S_ACK;
        end
      end
      S_WR:    state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      sext_q      <= 1'b0;
      wdata_q     <= 32'h0;
      lane_q      <= 2'b00;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      wdata_q     <= wdata_d;
      lane_q      <= lane_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ack       = (state_q == S_ACK);
  assign err       = ack && err_q;
  assign busy      = (state_q != S_IDLE);
  // Reset during WR must cancel the write in the same cycle.
  assign mem_we    = (state_q == S_WR) && !rst;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: behavioral word RAM, vector table of accesses,
// plus hand sequences for back-to-back requests and reset during WR.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sext = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ack, err, busy, mem_we;
  logic [31:0] rdata, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [7:0]  mem_addr;

  logic [31:0] ram [0:255];
  int          we_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  dmem_access_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .ack(ack), .err(err), .rdata(rdata),
    .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      we_cnt++;
    end
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          idx;
    logic [31:0] ram_exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic w, logic [1:0] sz, logic sx, logic [31:0] a,
                              logic [31:0] wd, int lt, logic e, logic [31:0] rd,
                              int ix, logic [31:0] re);
    vec_t v;
    v.we = w; v.size = sz; v.sext = sx; v.addr = a; v.wdata = wd;
    v.lat = lt; v.err = e; v.rdata = rd; v.idx = ix; v.ram_exp = re;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_access(input vec_t v, output int lat, output logic e, output int wes);
    int  wes0;
    bit  got;
    @(negedge clk);
    req = 1'b1; we = v.we; size = v.size; sext = v.sext; addr = v.addr; wdata = v.wdata;
    wes0 = we_cnt;
    lat = -1; e = 1'b0; got = 1'b0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1; lat = c; e = err;
      end else begin
        chk("err_without_ack", {31'h0, err}, 32'h0);
      end
    end
    req = 1'b0;
    if (!got) begin
      chk("ack_timeout", 32'h0, 32'h1);
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    end
    @(posedge clk); #1;
    wes = we_cnt - wes0;
  endtask

  initial begin
    int          lat, wes, c, wes0;
    logic        e;
    logic [31:0] held;
    logic [31:0] exp_rd;
    bit          got;

    // preload words through the DUT itself
    vecs.push_back(mk(1, 2'b10, 0, 32'h10010000, 32'h80F0FF81, 2, 0, 0, 0, 32'h80F0FF81));
    vecs.push_back(mk(1, 2'b10, 0, 32'h10010004, 32'h00000000, 2, 0, 0, 1, 32'h00000000));
    vecs.push_back(mk(1, 2'b10, 0, 32'h10010020, 32'h55667788, 2, 0, 0, 8, 32'h55667788));
    vecs.push_back(mk(1, 2'b10, 0, 32'h10010010, 32'h11223344, 2, 0, 0, 4, 32'h11223344));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10010010, 32'h0,        3, 0, 32'h11223344, 4, 32'h11223344));
    vecs.push_back(mk(1, 2'b00, 0, 32'h10010011, 32'hDEADBEAB, 4, 0, 0, 4, 32'h1122AB44));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10010010, 32'h0,        3, 0, 32'h1122AB44, 4, 32'h1122AB44));
    vecs.push_back(mk(0, 2'b00, 1, 32'h10010000, 32'h0, 3, 0, 32'hFFFFFF81, 0, 32'h80F0FF81));
    vecs.push_back(mk(0, 2'b00, 0, 32'h10010000, 32'h0, 3, 0, 32'h00000081, 0, 32'h80F0FF81));
    vecs.push_back(mk(0, 2'b01, 1, 32'h10010002, 32'h0, 3, 0, 32'hFFFF80F0, 0, 32'h80F0FF81));
    vecs.push_back(mk(0, 2'b01, 0, 32'h10010002, 32'h0, 3, 0, 32'h000080F0, 0, 32'h80F0FF81));
    vecs.push_back(mk(0, 2'b00, 1, 32'h10010001, 32'h0, 3, 0, 32'hFFFFFFFF, 0, 32'h80F0FF81));
    vecs.push_back(mk(0, 2'b00, 1, 32'h10010003, 32'h0, 3, 0, 32'hFFFFFF80, 0, 32'h80F0FF81));
    vecs.push_back(mk(0, 2'b00, 0, 32'h10010003, 32'h0, 3, 0, 32'h00000080, 0, 32'h80F0FF81));
    vecs.push_back(mk(0, 2'b01, 1, 32'h10010000, 32'h0, 3, 0, 32'hFFFFFF81, 0, 32'h80F0FF81));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10010400, 32'h0, 1, 1, 0, 0, 32'h80F0FF81));
    vecs.push_back(mk(0, 2'b11, 0, 32'h10010000, 32'h0, 1, 1, 0, 0, 32'h80F0FF81));
    vecs.push_back(mk(0, 2'b10, 0, 32'h1000FFFC, 32'h0, 1, 1, 0, 0, 32'h80F0FF81));
    vecs.push_back(mk(1, 2'b10, 0, 32'h10010400, 32'h12345678, 1, 1, 0, 0, 32'h80F0FF81));
    vecs.push_back(mk(1, 2'b01, 0, 32'h10010006, 32'h0000BEEF, 4, 0, 0, 1, 32'hBEEF0000));
    vecs.push_back(mk(0, 2'b01, 1, 32'h10010006, 32'h0, 3, 0, 32'hFFFFBEEF, 1, 32'hBEEF0000));
    vecs.push_back(mk(0, 2'b01, 0, 32'h10010004, 32'h0, 3, 0, 32'h00000000, 1, 32'hBEEF0000));
    vecs.push_back(mk(1, 2'b10, 0, 32'h100103FC, 32'hCAFEF00D, 2, 0, 0, 255, 32'hCAFEF00D));
    vecs.push_back(mk(0, 2'b10, 0, 32'h100103FC, 32'h0, 3, 0, 32'hCAFEF00D, 255, 32'hCAFEF00D));
    vecs.push_back(mk(1, 2'b00, 0, 32'h100103FF, 32'h00000011, 4, 0, 0, 255, 32'h11FEF00D));
    vecs.push_back(mk(1, 2'b11, 0, 32'h100103FC, 32'h0, 1, 1, 0, 255, 32'h11FEF00D));
`ifdef DMEM_ALIGN_CHECK_EN
    vecs.push_back(mk(0, 2'b10, 0, 32'h10010012, 32'h0, 1, 1, 0, 4, 32'h1122AB44));
    vecs.push_back(mk(0, 2'b01, 1, 32'h10010003, 32'h0, 1, 1, 0, 0, 32'h80F0FF81));
    vecs.push_back(mk(1, 2'b01, 0, 32'h10010001, 32'h00001234, 1, 1, 0, 0, 32'h80F0FF81));
`else
    vecs.push_back(mk(0, 2'b10, 0, 32'h10010012, 32'h0, 3, 0, 32'h1122AB44, 4, 32'h1122AB44));
    vecs.push_back(mk(0, 2'b01, 1, 32'h10010003, 32'h0, 3, 0, 32'hFFFF80F0, 0, 32'h80F0FF81));
    vecs.push_back(mk(1, 2'b01, 0, 32'h10010001, 32'h00001234, 4, 0, 0, 0, 32'h80F0FF81 & 32'hFFFF0000 | 32'h00001234));
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_addr", {24'h0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    held = 32'h0;
    foreach (vecs[i]) begin
      do_access(vecs[i], lat, e, wes);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_err", i), {31'h0, e}, {31'h0, vecs[i].err});
      exp_rd = (!vecs[i].we && !vecs[i].err) ? vecs[i].rdata : held;
      held = exp_rd;
      chk($sformatf("v%0d_rdata", i), rdata, exp_rd);
      chk($sformatf("v%0d_mem_we_pulses", i), wes, (vecs[i].we && !vecs[i].err) ? 1 : 0);
      chk($sformatf("v%0d_ram", i), ram[vecs[i].idx], vecs[i].ram_exp);
    end

    // back-to-back: req stays high through ack and is re-accepted after one IDLE cycle
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h10010010; wdata = 32'h0;
    got = 1'b0;
    for (c = 1; c <= 12 && !got; c++) begin
      @(posedge clk); #1;
      if (ack) got = 1'b1;
    end
    chk("b2b_first_ack", {31'h0, got}, 32'h1);
    @(posedge clk); #1;
    chk("b2b_idle_busy", {31'h0, busy}, 32'h0);
    chk("b2b_idle_ack", {31'h0, ack}, 32'h0);
    @(posedge clk); #1;
    chk("b2b_accept_busy", {31'h0, busy}, 32'h1);
    lat = -1;
    for (c = 2; c <= 12 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (ack) lat = c;
    end
    req = 1'b0;
    chk("b2b_second_latency", lat, 3);
    chk("b2b_rdata", rdata, 32'h1122AB44);
    @(posedge clk); #1;

    // reset asserted in the WR cycle of a byte store
    @(negedge clk);
    wes0 = we_cnt;
    req = 1'b1; we = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h10010020; wdata = 32'h00000099;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rstwr_busy_in_wr", {31'h0, busy}, 32'h1);
    chk("rstwr_mem_we_before_rst", {31'h0, mem_we}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rstwr_mem_we_gated", {31'h0, mem_we}, 32'h0);
    req = 1'b0;
    @(posedge clk); #1;
    chk("rstwr_no_ack", {31'h0, ack}, 32'h0);
    chk("rstwr_busy_after", {31'h0, busy}, 32'h0);
    chk("rstwr_rdata_reset", rdata, 32'h0);
    rst = 1'b0;
    chk("rstwr_no_write_pulse", we_cnt - wes0, 0);
    chk("rstwr_ram_unchanged", ram[8], 32'h55667788);

    do_access(mk(0, 2'b10, 0, 32'h10010020, 32'h0, 3, 0, 32'h55667788, 8, 32'h55667788), lat, e, wes);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_rdata", rdata, 32'h55667788);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
